// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared types and constants for the ID/EX pipeline stage
// Holds the register-index width, ALU operation encodings and the stall FSM state encoding.
package id_ex_stage_pkg;

    localparam int REGW     = 5;
    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } stall_state_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side inputs and execute-side outputs of the ID/EX register
// master: decode/control side (drives id_*, flush, ext_hold; observes ex_*, stall, stall_cnt)
// slave : the id_ex_stage register (the reverse directions)
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = 16
);
    logic                id_valid;
    logic [REGW-1:0]     id_rs1;
    logic [REGW-1:0]     id_rs2;
    logic [REGW-1:0]     id_rd;
    logic                id_uses_rs2;
    logic                id_regwrite;
    logic                id_memread;
    logic                id_memwrite;
    logic [ALU_OP_W-1:0] id_alu_op;
    logic [XLEN-1:0]     id_rdata1;
    logic [XLEN-1:0]     id_rdata2;
    logic [XLEN-1:0]     id_imm;
    logic [XLEN-1:0]     id_pc;
    logic                flush;
    logic                ext_hold;

    logic                ex_valid;
    logic                ex_regwrite;
    logic                ex_memread;
    logic                ex_memwrite;
    logic [REGW-1:0]     ex_rs1;
    logic [REGW-1:0]     ex_rs2;
    logic [REGW-1:0]     ex_rd;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic [XLEN-1:0]     ex_rdata1;
    logic [XLEN-1:0]     ex_rdata2;
    logic [XLEN-1:0]     ex_imm;
    logic [XLEN-1:0]     ex_pc;
    logic                stall;
    logic [CNTW-1:0]     stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_uses_rs2, id_regwrite, id_memread,
               id_memwrite, id_alu_op, id_rdata1, id_rdata2, id_imm, id_pc, flush, ext_hold,
        input  ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_rs1, ex_rs2, ex_rd,
               ex_alu_op, ex_rdata1, ex_rdata2, ex_imm, ex_pc, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_uses_rs2, id_regwrite, id_memread,
               id_memwrite, id_alu_op, id_rdata1, id_rdata2, id_imm, id_pc, flush, ext_hold,
        output ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_rs1, ex_rs2, ex_rd,
               ex_alu_op, ex_rdata1, ex_rdata2, ex_imm, ex_pc, stall, stall_cnt
    );

endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard compare
// Inputs : EX-side valid/memread/rd, ID-side valid/rs1/rs2/uses_rs2
// Output : o_load_use, high when the instruction in decode needs a load result still in EX
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic            i_ex_valid,
    input  logic            i_ex_memread,
    input  logic [REGW-1:0] i_ex_rd,
    input  logic            i_id_valid,
    input  logic [REGW-1:0] i_id_rs1,
    input  logic [REGW-1:0] i_id_rs2,
    input  logic            i_id_uses_rs2,
    output logic            o_load_use
);
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = (i_ex_rd == i_id_rs1);
    assign w_rs2_hit = i_id_uses_rs2 & (i_ex_rd == i_id_rs2);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign o_load_use = i_ex_valid & i_ex_memread & (i_ex_rd != '0) & i_id_valid
                      & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion and stall counter
// clk, rst_n : clock and asynchronous active-low reset
// bus        : id_ex_stage_if.slave carrying id_* inputs, flush, ext_hold, ex_* outputs,
//              combinational stall and the saturating load-use bubble count stall_cnt
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CNTW = 16
)(
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    logic                r_ex_valid;
    logic                r_ex_regwrite;
    logic                r_ex_memread;
    logic                r_ex_memwrite;
    logic [REGW-1:0]     r_ex_rs1;
    logic [REGW-1:0]     r_ex_rs2;
    logic [REGW-1:0]     r_ex_rd;
    logic [ALU_OP_W-1:0] r_ex_alu_op;
    logic [XLEN-1:0]     r_ex_rdata1;
    logic [XLEN-1:0]     r_ex_rdata2;
    logic [XLEN-1:0]     r_ex_imm;
    logic [XLEN-1:0]     r_ex_pc;
    logic [CNTW-1:0]     r_stall_cnt;
    stall_state_e        r_state;

    logic                w_load_use;
    logic                w_cnt_max;
    logic                w_id_live;

    load_use_detect u_load_use_detect (
        .i_ex_valid    (r_ex_valid),
        .i_ex_memread  (r_ex_memread),
        .i_ex_rd       (r_ex_rd),
        .i_id_valid    (bus.id_valid),
        .i_id_rs1      (bus.id_rs1),
        .i_id_rs2      (bus.id_rs2),
        .i_id_uses_rs2 (bus.id_uses_rs2),
        .o_load_use    (w_load_use)
    );

    // A redirect kills the decode-side instruction, so there is nothing to stall for
    assign bus.stall = w_load_use & ~bus.flush;

    assign w_cnt_max = (r_stall_cnt == {CNTW{1'b1}});
    assign w_id_live = bus.id_valid;

    // Bubbles clear only controls and indices; datapath fields keep their old contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_ex_alu_op   <= '0;
            r_ex_rdata1   <= '0;
            r_ex_rdata2   <= '0;
            r_ex_imm      <= '0;
            r_ex_pc       <= '0;
            r_stall_cnt   <= '0;
            r_state       <= ST_RUN;
        end else if (bus.flush) begin
            r_ex_valid    <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_state       <= ST_RUN;
        end else if (bus.ext_hold) begin
            r_state       <= r_state;
        end else if (w_load_use) begin
            r_ex_valid    <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_rs1      <= '0;
            r_ex_rs2      <= '0;
            r_ex_rd       <= '0;
            r_state       <= ST_BUBBLE;
            if ((r_state == ST_RUN) && !w_cnt_max)
                r_stall_cnt <= r_stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            r_ex_valid    <= w_id_live;
            r_ex_regwrite <= w_id_live & bus.id_regwrite;
            r_ex_memread  <= w_id_live & bus.id_memread;
            r_ex_memwrite <= w_id_live & bus.id_memwrite;
            r_ex_rs1      <= w_id_live ? bus.id_rs1 : '0;
            r_ex_rs2      <= w_id_live ? bus.id_rs2 : '0;
            r_ex_rd       <= w_id_live ? bus.id_rd  : '0;
            r_ex_alu_op   <= bus.id_alu_op;
            r_ex_rdata1   <= bus.id_rdata1;
            r_ex_rdata2   <= bus.id_rdata2;
            r_ex_imm      <= bus.id_imm;
            r_ex_pc       <= bus.id_pc;
            r_state       <= ST_RUN;
        end
    end

    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_regwrite = r_ex_regwrite;
    assign bus.ex_memread  = r_ex_memread;
    assign bus.ex_memwrite = r_ex_memwrite;
    assign bus.ex_rs1      = r_ex_rs1;
    assign bus.ex_rs2      = r_ex_rs2;
    assign bus.ex_rd       = r_ex_rd;
    assign bus.ex_alu_op   = r_ex_alu_op;
    assign bus.ex_rdata1   = r_ex_rdata1;
    assign bus.ex_rdata2   = r_ex_rdata2;
    assign bus.ex_imm      = r_ex_imm;
    assign bus.ex_pc       = r_ex_pc;
    assign bus.stall_cnt   = r_stall_cnt;

endmodule
